instr_feeder: RTL



---
 rtl/feeder_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/instr_feeder.sv | 107 ++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// Shared types and defaults for the instruction feeder.
package feeder_pkg;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_INSTR_W = 11;
  localparam int DEF_BUS_W   = 16;

  // state | meaning
  // IDLE  | nothing presented; waiting for a queued instruction
  // ISSUE | new instruction on the bus; start pulses this cycle
  // BUSY  | instruction held until the processor signals done
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // One extra bit over the address width separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a sticky overflow flag.
module sync_fifo
  import feeder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_INSTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance and overflow capture; a write while full is dropped even if a pop happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: queues host instructions and hands them one at a time
// to the processor, holding each until done is pulsed.
// Optional macro INSTR_FEEDER_RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int BUS_W   = DEF_BUS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               cpu_done,
  output logic [BUS_W-1:0]   instr_out,
  output logic               instr_valid,
  output logic               start,
  output logic               empty,
  output logic               overflow
`ifdef INSTR_FEEDER_RETIRE_CNT_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               load;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] head;
  logic [BUS_W-1:0]   instr_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (load),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // Next-state: loading the head and popping the FIFO are the same event.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (cpu_done) begin
          if (!fifo_empty) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output register; value is kept after the last instruction retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     instr_q <= '0;
    else if (load) instr_q <= BUS_W'(head);
  end

  assign instr_out   = instr_q;
  assign instr_valid = (state_q != IDLE);
  assign start       = (state_q == ISSUE);
  assign wr_ready    = !fifo_full;
  assign empty       = fifo_empty;

`ifdef INSTR_FEEDER_RETIRE_CNT_EN
  logic [15:0] retired_cnt_q;

  // Count each done accepted in BUSY; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            retired_cnt_q <= '0;
    else if (state_q == BUSY && cpu_done) retired_cnt_q <= retired_cnt_q + 16'd1;
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
